threshold_monitor: RTL and testbench

- Streaming 4-bit threshold monitor; sits downstream of the 4-bit magnitude-compare stage and consumes its greater/less/equal result for each sample.
- Stores a programmable threshold and debounces the compare result with a confirm-count FSM.
- Raises a registered alarm after CONFIRM consecutive above-threshold samples; clears it after CONFIRM consecutive not-above samples.
- Emits single-cycle rise/fall event pulses for the downstream logger/LED stage.

---
 rtl/thresh_pkg.sv | 18 +
 rtl/mag_cmp4.sv | 19 +
 rtl/threshold_monitor.sv | 166 ++++++++++++++++
 tb/tb_threshold_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/thresh_pkg.sv
// Shared definitions for the threshold monitor: FSM state encoding,
// default widths and the threshold reset value.
package thresh_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMING   = 2'd1,
        ALARM    = 2'd2,
        CLEARING = 2'd3
    } state_e;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_CONFIRM = 3;

    // Threshold resets to all ones so nothing arms before a real threshold.
    localparam logic [DEF_WIDTH-1:0] THR_RST = '1;

endpackage

// File: rtl/mag_cmp4.sv
// Combinational unsigned magnitude comparator.
// Ports: a, b (WIDTH) in; gt (a>b), lt (a<b), eq (a==b) out.
module mag_cmp4 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    always_comb begin
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/threshold_monitor.sv
// Debounced threshold monitor: programmable threshold, confirm-count FSM,
// registered alarm with one-cycle rise/fall pulses.
// Ports: clk, rst (async, active-high), thr_load/thr_in (threshold write),
//        in_valid/sample (input stream), alarm, rise, fall, above, state.
// Optional: define THRESH_HYST_EN to clear only when sample < thr - HYST.
module threshold_monitor
    import thresh_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CONFIRM = DEF_CONFIRM,
    parameter int CNT_W   = 4,
    parameter int HYST    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             thr_load,
    input  logic [WIDTH-1:0] thr_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             alarm,
    output logic             rise,
    output logic             fall,
    output logic             above,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CONF_C = CNT_W'(CONFIRM);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [WIDTH-1:0] thr_q, thr_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alarm_q, alarm_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             above_q, above_d;

    logic             arm_gt, arm_lt, arm_eq;
    logic             clr_hit;
    logic [CNT_W-1:0] cnt_inc;

    // Compare always uses the currently stored (old) threshold.
    mag_cmp4 #(.WIDTH(WIDTH)) u_arm_cmp (
        .a  (sample),
        .b  (thr_q),
        .gt (arm_gt),
        .lt (arm_lt),
        .eq (arm_eq)
    );

`ifdef THRESH_HYST_EN
    logic [WIDTH-1:0] clr_thr;
    logic             hy_gt, hy_lt, hy_eq;

    // Clear level is thr - HYST, saturating at 0 (then never clears).
    always_comb begin
        if (thr_q > WIDTH'(HYST)) clr_thr = thr_q - WIDTH'(HYST);
        else                      clr_thr = '0;
    end

    mag_cmp4 #(.WIDTH(WIDTH)) u_hyst_cmp (
        .a  (sample),
        .b  (clr_thr),
        .gt (hy_gt),
        .lt (hy_lt),
        .eq (hy_eq)
    );

    assign clr_hit = hy_lt;
`else
    assign clr_hit = arm_lt | arm_eq;
`endif

    assign cnt_inc = cnt_q + ONE_C;

    always_comb begin
        thr_d   = thr_load ? thr_in : thr_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        above_d = in_valid ? arm_gt : above_q;
        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (arm_gt) begin
                        if (CONFIRM == 1) begin
                            state_d = ALARM;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ARMING;
                            cnt_d   = ONE_C;
                        end
                    end
                end
                ARMING: begin
                    if (!arm_gt) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CONF_C) begin
                        state_d = ALARM;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                ALARM: begin
                    if (clr_hit) begin
                        if (CONFIRM == 1) begin
                            state_d = IDLE;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = CLEARING;
                            cnt_d   = ONE_C;
                        end
                    end
                end
                CLEARING: begin
                    if (!clr_hit) begin
                        state_d = ALARM;
                        cnt_d   = '0;
                    end else if (cnt_inc == CONF_C) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        alarm_d = (state_d == ALARM) || (state_d == CLEARING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q   <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            above_q <= 1'b0;
        end else begin
            thr_q   <= thr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            above_q <= above_d;
        end
    end

    assign alarm = alarm_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign above = above_q;
    assign state = state_q;

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed testbench for threshold_monitor.
// Observed vector per cycle: {state[1:0], alarm, rise, fall, above}.
module tb_threshold_monitor;

    typedef struct packed {
        logic       v;
        logic       ld;
        logic [3:0] t;
        logic [3:0] s;
        logic [5:0] e;
    } row_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       thr_load = 1'b0;
    logic [3:0] thr_in = '0;
    logic       in_valid = 1'b0;
    logic [3:0] sample = '0;
    logic       alarm, rise, fall, above;
    logic [1:0] state;

    int vecs = 0;
    int errs = 0;

    threshold_monitor dut (
        .clk      (clk),
        .rst      (rst),
        .thr_load (thr_load),
        .thr_in   (thr_in),
        .in_valid (in_valid),
        .sample   (sample),
        .alarm    (alarm),
        .rise     (rise),
        .fall     (fall),
        .above    (above),
        .state    (state)
    );

    always #5 clk = ~clk;

    wire [5:0] obs = {state, alarm, rise, fall, above};

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input row_t r);
        in_valid = r.v;
        thr_load = r.ld;
        thr_in   = r.t;
        sample   = r.s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        thr_load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (obs !== 6'b00_0000) begin
            errs++;
            $display("FAIL reset obs=%b exp=%b", obs, 6'b00_0000);
        end
        rst = 1'b0;
    endtask

    task automatic test_equal_no_arm;
        row_t tbl [3];
        tbl = '{
            '{1'b1, 1'b0, 4'd0, 4'd15, 6'b00_0000},
            '{1'b1, 1'b0, 4'd0, 4'd15, 6'b00_0000},
            '{1'b1, 1'b0, 4'd0, 4'd15, 6'b00_0000}
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            vecs++;
            if (obs !== tbl[i].e) begin
                errs++;
                $display("FAIL equal[%0d] obs=%b exp=%b", i, obs, tbl[i].e);
            end
        end
    endtask

    task automatic test_arm;
        row_t tbl [5];
        tbl = '{
            '{1'b0, 1'b1, 4'd8, 4'd0,  6'b00_0000},
            '{1'b1, 1'b0, 4'd0, 4'd9,  6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd10, 6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd11, 6'b10_1101},
            '{1'b0, 1'b0, 4'd0, 4'd0,  6'b10_1001}
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            vecs++;
            if (obs !== tbl[i].e) begin
                errs++;
                $display("FAIL arm[%0d] obs=%b exp=%b", i, obs, tbl[i].e);
            end
        end
    endtask

    task automatic test_clear;
        row_t tbl [6];
        tbl = '{
            '{1'b1, 1'b0, 4'd0, 4'd5, 6'b11_1000},
            '{1'b1, 1'b0, 4'd0, 4'd9, 6'b10_1001},
            '{1'b1, 1'b0, 4'd0, 4'd5, 6'b11_1000},
            '{1'b1, 1'b0, 4'd0, 4'd5, 6'b11_1000},
            '{1'b1, 1'b0, 4'd0, 4'd5, 6'b00_0010},
            '{1'b0, 1'b0, 4'd0, 4'd0, 6'b00_0000}
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            vecs++;
            if (obs !== tbl[i].e) begin
                errs++;
                $display("FAIL clear[%0d] obs=%b exp=%b", i, obs, tbl[i].e);
            end
        end
    endtask

    task automatic test_gaps;
        row_t tbl [14];
        tbl = '{
            '{1'b1, 1'b0, 4'd0, 4'd9, 6'b01_0001},
            '{1'b0, 1'b0, 4'd0, 4'd9, 6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd9, 6'b01_0001},
            '{1'b0, 1'b0, 4'd0, 4'd9, 6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd4, 6'b00_0000},
            '{1'b0, 1'b0, 4'd0, 4'd9, 6'b00_0000},
            '{1'b1, 1'b0, 4'd0, 4'd9, 6'b01_0001},
            '{1'b0, 1'b0, 4'd0, 4'd0, 6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd9, 6'b01_0001},
            '{1'b0, 1'b0, 4'd0, 4'd0, 6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd9, 6'b10_1101},
            '{1'b1, 1'b0, 4'd0, 4'd0, 6'b11_1000},
            '{1'b1, 1'b0, 4'd0, 4'd0, 6'b11_1000},
            '{1'b1, 1'b0, 4'd0, 4'd0, 6'b00_0010}
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            vecs++;
            if (obs !== tbl[i].e) begin
                errs++;
                $display("FAIL gaps[%0d] obs=%b exp=%b", i, obs, tbl[i].e);
            end
        end
    endtask

    task automatic test_thr_same_cycle;
        row_t tbl [5];
        tbl = '{
            '{1'b1, 1'b1, 4'd2, 4'd5, 6'b00_0000},
            '{1'b1, 1'b0, 4'd0, 4'd5, 6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd5, 6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd5, 6'b10_1101},
            '{1'b1, 1'b0, 4'd0, 4'd0, 6'b11_1000}
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            vecs++;
            if (obs !== tbl[i].e) begin
                errs++;
                $display("FAIL thr_same[%0d] obs=%b exp=%b", i, obs, tbl[i].e);
            end
        end
    endtask

    // Starts in CLEARING with thr=2; reset must act without a clock edge.
    task automatic test_async_reset;
        row_t r;
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if (obs !== 6'b00_0000) begin
            errs++;
            $display("FAIL async_rst obs=%b exp=%b", obs, 6'b00_0000);
        end
        @(posedge clk);
        #1;
        vecs++;
        if (obs !== 6'b00_0000) begin
            errs++;
            $display("FAIL rst_hold obs=%b exp=%b", obs, 6'b00_0000);
        end
        rst = 1'b0;
        // Threshold must be back at 15: sample 5 is not above.
        r = '{1'b1, 1'b0, 4'd0, 4'd5, 6'b00_0000};
        drive(r);
        vecs++;
        if (obs !== r.e) begin
            errs++;
            $display("FAIL rst_thr obs=%b exp=%b", obs, r.e);
        end
    endtask

`ifdef THRESH_HYST_EN
    task automatic test_hyst;
        row_t tbl [10];
        tbl = '{
            '{1'b0, 1'b1, 4'd8, 4'd0, 6'b00_0000},
            '{1'b1, 1'b0, 4'd0, 4'd9, 6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd9, 6'b01_0001},
            '{1'b1, 1'b0, 4'd0, 4'd9, 6'b10_1101},
            '{1'b1, 1'b0, 4'd0, 4'd7, 6'b10_1000},
            '{1'b1, 1'b0, 4'd0, 4'd7, 6'b10_1000},
            '{1'b1, 1'b0, 4'd0, 4'd7, 6'b10_1000},
            '{1'b1, 1'b0, 4'd0, 4'd6, 6'b11_1000},
            '{1'b1, 1'b0, 4'd0, 4'd6, 6'b11_1000},
            '{1'b1, 1'b0, 4'd0, 4'd6, 6'b00_0010}
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            vecs++;
            if (obs !== tbl[i].e) begin
                errs++;
                $display("FAIL hyst[%0d] obs=%b exp=%b", i, obs, tbl[i].e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_equal_no_arm();
        test_arm();
        test_clear();
        test_gaps();
        test_thr_same_cycle();
        test_async_reset();
`ifdef THRESH_HYST_EN
        test_hyst();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
